// File: rtl/vga_sync_decoder_module.sv
// VGA sync decoder: measures incoming line/frame timing, locks onto it and emits active-area pixels with coordinates.
// Build option VGA_DECODE_HALFRES_EN: halves Xpos/Ypos and marks only even-column/even-row pixels valid.
//
// state   | meaning
// SEARCH  | no timing reference, waiting for a VSYNC falling edge
// MEASURE | checking line and frame totals over two consecutive frames
// LOCKED  | timing matches parameters, pixels are being reported
module vga_sync_decoder_module #(
   parameter int H_SYNC   = 96,
   parameter int H_BACK   = 48,
   parameter int H_ACTIVE = 640,
   parameter int H_FRONT  = 16,
   parameter int V_SYNC   = 2,
   parameter int V_BACK   = 33,
   parameter int V_ACTIVE = 480,
   parameter int V_FRONT  = 10
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        HSYNC,
   input  logic        VSYNC,
   input  logic [7:0]  R,
   input  logic [7:0]  G,
   input  logic [7:0]  B,
   output logic [7:0]  PixR,
   output logic [7:0]  PixG,
   output logic [7:0]  PixB,
   output logic [9:0]  Xpos,
   output logic [9:0]  Ypos,
   output logic        PixValid,
   output logic        FrameStart,
   output logic        Locked,
   output logic        SyncErr,
   output logic [11:0] HTotal,
   output logic [11:0] VTotal
);

   localparam logic [11:0] H_TOT   = 12'(H_SYNC + H_BACK + H_ACTIVE + H_FRONT);
   localparam logic [11:0] V_TOT   = 12'(V_SYNC + V_BACK + V_ACTIVE + V_FRONT);
   localparam logic [11:0] H_FIRST = 12'(H_SYNC + H_BACK);
   localparam logic [11:0] H_LAST  = 12'(H_SYNC + H_BACK + H_ACTIVE - 1);
   localparam logic [11:0] V_FIRST = 12'(V_SYNC + V_BACK);
   localparam logic [11:0] V_LAST  = 12'(V_SYNC + V_BACK + V_ACTIVE - 1);
   localparam logic [11:0] CNT_MAX = 12'hFFF;

   typedef enum logic [1:0] {
      SEARCH  = 2'd0,
      MEASURE = 2'd1,
      LOCKED  = 2'd2
   } state_t;

   state_t      state, stateNext;
   logic        goodCnt, goodCntNext;
   logic        errPulse;

   logic        hsReg, vsReg, hsDly, vsDly;
   logic [7:0]  rReg, gReg, bReg;
   logic        hFall, vFall, vPending, vStart;
   logic [11:0] hcnt, vcnt, hNext, vNext;
   logic [11:0] hTotNew, vTotNew;
   logic        hBad, vBad, hSat;
   logic        inWin, pixOk;
   logic [9:0]  xFull, yFull, xCalc, yCalc;

   always_ff @(posedge CLK) begin
      if (RST) begin
         hsReg <= 1'b1;
         vsReg <= 1'b1;
         hsDly <= 1'b1;
         vsDly <= 1'b1;
         rReg  <= '0;
         gReg  <= '0;
         bReg  <= '0;
      end else begin
         hsReg <= HSYNC;
         vsReg <= VSYNC;
         hsDly <= hsReg;
         vsDly <= vsReg;
         rReg  <= R;
         gReg  <= G;
         bReg  <= B;
      end
   end

   assign hFall = hsDly & ~hsReg;
   assign vFall = vsDly & ~vsReg;

   // hNext/vNext are the coordinates of the pixel currently held in rReg/gReg/bReg.
   assign hNext   = hFall ? 12'd0 : ((hcnt == CNT_MAX) ? CNT_MAX : hcnt + 12'd1);
   assign vStart  = hFall & (vPending | vFall);
   assign vNext   = vStart ? 12'd0 :
                    ((hFall && (vcnt != CNT_MAX)) ? vcnt + 12'd1 : vcnt);
   assign hTotNew = (hcnt == CNT_MAX) ? CNT_MAX : hcnt + 12'd1;
   assign vTotNew = (vcnt == CNT_MAX) ? CNT_MAX : vcnt + 12'd1;

   assign hBad = hFall & (hTotNew != H_TOT);
   assign vBad = vFall & (vTotNew != V_TOT);
   assign hSat = (hcnt == CNT_MAX);

   always_ff @(posedge CLK) begin
      if (RST) begin
         hcnt     <= '0;
         vcnt     <= '0;
         vPending <= 1'b0;
         HTotal   <= '0;
         VTotal   <= '0;
      end else begin
         hcnt <= hNext;
         vcnt <= vNext;
         if (hFall) begin
            vPending <= 1'b0;
         end else if (vFall) begin
            vPending <= 1'b1;
         end
         if (hFall) begin
            HTotal <= hTotNew;
         end
         if (vFall) begin
            VTotal <= vTotNew;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state   <= SEARCH;
         goodCnt <= 1'b0;
      end else begin
         state   <= stateNext;
         goodCnt <= goodCntNext;
      end
   end

   always_comb begin
      stateNext   = state;
      goodCntNext = goodCnt;
      errPulse    = 1'b0;
      case (state)
         SEARCH: begin
            if (vFall) begin
               stateNext   = MEASURE;
               goodCntNext = 1'b0;
            end
         end
         MEASURE: begin
            if (hBad || vBad || hSat) begin
               stateNext = SEARCH;
            end else if (vFall) begin
               if (goodCnt) begin
                  stateNext = LOCKED;
               end else begin
                  goodCntNext = 1'b1;
               end
            end
         end
         LOCKED: begin
            if (hBad || vBad || hSat) begin
               stateNext = SEARCH;
               errPulse  = 1'b1;
            end
         end
         default: stateNext = SEARCH;
      endcase
   end

   assign inWin = (hNext >= H_FIRST) && (hNext <= H_LAST) &&
                  (vNext >= V_FIRST) && (vNext <= V_LAST);
   assign xFull = 10'(hNext - H_FIRST);
   assign yFull = 10'(vNext - V_FIRST);

`ifdef VGA_DECODE_HALFRES_EN
   assign xCalc = {1'b0, xFull[9:1]};
   assign yCalc = {1'b0, yFull[9:1]};
   assign pixOk = inWin & ~xFull[0] & ~yFull[0];
`else
   assign xCalc = xFull;
   assign yCalc = yFull;
   assign pixOk = inWin;
`endif

   // Qualify with stateNext so PixValid never outlives Locked on a lock-loss edge.
   always_ff @(posedge CLK) begin
      if (RST) begin
         PixR       <= '0;
         PixG       <= '0;
         PixB       <= '0;
         Xpos       <= '0;
         Ypos       <= '0;
         PixValid   <= 1'b0;
         FrameStart <= 1'b0;
         SyncErr    <= 1'b0;
      end else begin
         PixR <= rReg;
         PixG <= gReg;
         PixB <= bReg;
         if (inWin) begin
            Xpos <= xCalc;
            Ypos <= yCalc;
         end
         PixValid   <= (stateNext == LOCKED) && pixOk;
         FrameStart <= (stateNext == LOCKED) && inWin && (xFull == 10'd0) && (yFull == 10'd0);
         SyncErr    <= errPulse;
      end
   end

   assign Locked = (state == LOCKED);

endmodule

// File: doc/vga_sync_decoder_module.md
VGA_SYNC_DECODER_MODULE -- requirements
Module: vga_sync_decoder_module

Interface
REQ-001 Parameters SHALL be (name, default, meaning): H_SYNC 96 hsync pixels; H_BACK 48 h back porch; H_ACTIVE 640 visible pixels; H_FRONT 16 h front porch; V_SYNC 2 vsync lines; V_BACK 33 v back porch; V_ACTIVE 480 visible lines; V_FRONT 10 v front porch.
REQ-002 CLK input 1: pixel clock, all logic on rising edge.
REQ-003 RST input 1: reset, synchronous, active-high.
REQ-004 HSYNC input 1: horizontal sync, active-low pulse.
REQ-005 VSYNC input 1: vertical sync, active-low pulse.
REQ-006 R, G, B input 8 each: incoming pixel colour.
REQ-007 PixR, PixG, PixB output 8 each: registered pixel colour aligned with PixValid.
REQ-008 Xpos output 10: active-area column; Ypos output 10: active-area row.
REQ-009 PixValid output 1: high while Xpos/Ypos/Pix* describe a visible pixel and Locked=1.
REQ-010 FrameStart output 1: one-cycle pulse with the first valid pixel (0,0) of each locked frame.
REQ-011 Locked output 1: timing matches parameters; SyncErr output 1: one-cycle pulse on lock loss.
REQ-012 HTotal output 12: last measured clocks per line; VTotal output 12: last measured lines per frame.

Function
REQ-013 HSYNC/VSYNC/R/G/B SHALL be registered once; sync falling edges detected on registered values.
REQ-014 Horizontal counter hcnt SHALL load 0 on the HSYNC falling edge, else increment, saturating at 4095.
REQ-015 Vertical counter vcnt SHALL load 0 on the first HSYNC falling edge after a VSYNC falling edge, else increment per HSYNC falling edge, saturating at 4095.
REQ-016 On each HSYNC falling edge HTotal SHALL take hcnt+1; on each VSYNC falling edge VTotal SHALL take vcnt+1.
REQ-017 Active window: hcnt in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_ACTIVE-1] and vcnt in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_ACTIVE-1].
REQ-018 Xpos = hcnt-(H_SYNC+H_BACK), Ypos = vcnt-(V_SYNC+V_BACK), held at last value outside the window.
REQ-019 Latency from R/G/B at input to matching PixR/G/B with PixValid SHALL be exactly 2 CLK cycles.
REQ-020 FSM states SEARCH, MEASURE, LOCKED; reset state SEARCH.
REQ-021 SEARCH -> MEASURE on a VSYNC falling edge.
REQ-022 MEASURE -> LOCKED after two consecutive VSYNC edges where every line's HTotal and the VTotal equal expected totals (800, 525 default); any mismatch -> SEARCH.
REQ-023 LOCKED -> SEARCH with SyncErr pulse on any HTotal or VTotal mismatch, or hcnt reaching 4095.
REQ-024 Locked SHALL be 1 only in LOCKED; PixValid and FrameStart SHALL be 0 outside LOCKED.
REQ-025 Simultaneous HSYNC and VSYNC falling edges SHALL apply both HTotal and VTotal updates in the same cycle.

Reset
REQ-026 RST SHALL set FSM SEARCH, hcnt/vcnt/HTotal/VTotal 0, Xpos/Ypos 0, Pix* 0, PixValid/FrameStart/Locked/SyncErr 0, sync registers 1.
REQ-027 RST asserted mid-frame SHALL drop Locked next cycle without a SyncErr pulse; relock requires REQ-021/022 again.

Configuration
REQ-028 Macro VGA_DECODE_HALFRES_EN: when defined, Xpos/Ypos SHALL be the full-resolution values shifted right by 1 (320x240 game grid) and PixValid SHALL assert only on even column and even row; when undefined, full-resolution Xpos/Ypos and PixValid on every active pixel.

Verification
REQ-029 Ideal 640x480@800x525 stream, 3 frames -> Locked=1 at start of frame 3, HTotal=800, VTotal=525, FrameStart at Xpos=0/Ypos=0.
REQ-030 Pixel R=8'hAB at hcnt=144, vcnt=35 -> PixR=8'hAB, Xpos=0, Ypos=0, PixValid=1 exactly 2 cycles later.
REQ-031 While locked, one line of 799 clocks -> SyncErr single pulse, Locked=0, HTotal=799.
REQ-032 RST pulse at Ypos=200 in locked state -> all outputs 0 next cycle, SyncErr stays 0, relock after 2 good frames.
REQ-033 HSYNC held high 5000 clocks -> hcnt saturates at 4095, Locked=0, no counter wrap.
REQ-034 VGA_DECODE_HALFRES_EN defined, full-res pixel (639,479) -> Xpos=319, Ypos=239, PixValid=0; pixel (638,478) -> PixValid=1.
